// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - shared types and sizing helpers for the Izhikevich neuron blocks
package izh_pkg;

  // Accumulator scan sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int N_PRE_DEFAULT = 64;
  localparam int I_W_DEFAULT   = 16;

  // Width that holds the sum of n_pre signed words of weight_w bits without overflow
  function automatic int acc_width(input int weight_w, input int n_pre);
    return weight_w + $clog2(n_pre);
  endfunction

endpackage

// File: rtl/sat_signed.sv
// rtl/sat_signed.sv - combinational signed clamp from ACC_W to I_W bits
module sat_signed #(
  parameter int ACC_W = 38,
  parameter int I_W   = 16
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [I_W-1:0]   dout
);

  // Bits above the output sign must all agree with it for the value to fit
  localparam int HI_W = ACC_W - I_W + 1;

  logic [HI_W-1:0] hi;

  assign hi = din[ACC_W-1:I_W-1];

  // Pass through when representable, otherwise clamp toward the sign of din
  always_comb begin
    dout = din[I_W-1:0];
    if (!((hi == '0) || (hi == '1))) begin
      if (din[ACC_W-1]) dout = {1'b1, {(I_W-1){1'b0}}};
      else              dout = {1'b0, {(I_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/synapse_accumulator.sv
// rtl/synapse_accumulator.sv - scans weight RAM and sums weights of spiking inputs into i_syn
module synapse_accumulator
  import izh_pkg::*;
#(
  parameter int NEURON_ADR = 5,
  parameter int WEIGHTS    = 31,
  parameter int N_PRE      = N_PRE_DEFAULT,
  parameter int I_W        = I_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_PRE-1:0]        spikes,
  output logic [NEURON_ADR:0]     rd_addr,
  input  logic [WEIGHTS:0]        rd_data,
  output logic                    busy,
  output logic                    done,
  output logic signed [I_W-1:0]   i_syn
);

  localparam int ADR_W = NEURON_ADR + 1;
  localparam int ACC_W = acc_width(WEIGHTS + 1, N_PRE);
  localparam logic [ADR_W-1:0] K_LAST = ADR_W'(N_PRE - 1);

  state_t                  state;
  logic [ADR_W-1:0]        k;
  logic [N_PRE-1:0]        spike_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [I_W-1:0]   sat_out;

  // Current address's contribution, so the final term is included in the saturated result
  always_comb begin
    addend   = '0;
    if (spike_reg[k]) addend = ACC_W'($signed(rd_data));
    acc_next = acc + addend;
  end

  sat_signed #(
    .ACC_W (ACC_W),
    .I_W   (I_W)
  ) u_sat (
    .din  (acc_next),
    .dout (sat_out)
  );

  assign rd_addr = (state == ST_SCAN) ? k : '0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  // Capture request, walk addresses 0..N_PRE-1, publish saturated sum, then return to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      acc       <= '0;
      spike_reg <= '0;
      i_syn     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            spike_reg <= spikes;
            acc       <= '0;
            k         <= '0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          acc <= acc_next;
          if (k == K_LAST) begin
            i_syn <= sat_out;
            state <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_accumulator.sv
// tb/tb_synapse_accumulator.sv - randomized self-checking bench for synapse_accumulator
module tb_synapse_accumulator;

  localparam int N = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [N-1:0]       spikes = '0;
  logic [5:0]         rd_addr;
  logic [31:0]        rd_data;
  logic               busy;
  logic               done;
  logic signed [15:0] i_syn;

  logic [31:0] ram [0:N-1];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: scan progress measured in edges since acceptance
  bit     m_active = 0;
  int     m_n = 0;
  longint m_result = 0;
  longint m_isyn = 0;

  synapse_accumulator dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .spikes  (spikes),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .i_syn   (i_syn)
  );

  assign rd_data = ram[rd_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint exp_sum(input logic [N-1:0] v);
    longint s = 0;
    for (int i = 0; i < N; i++)
      if (v[i]) s += longint'($signed(ram[i]));
    return sat16(s);
  endfunction

  // Model: accept in idle, result appears N edges after acceptance, idle again one edge later
  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      m_n      = 0;
      m_isyn   = 0;
    end else if (m_active) begin
      m_n++;
      if (m_n == N) m_isyn = m_result;
      if (m_n == N + 1) m_active = 0;
    end else if (start) begin
      m_active = 1;
      m_n      = 0;
      m_result = exp_sum(spikes);
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_rd_addr", longint'(rd_addr), 0);
      chk("rst_i_syn", longint'(i_syn), 0);
    end else begin
      chk("busy", longint'(busy), longint'(m_active));
      chk("done", longint'(done), longint'(m_active && m_n == N));
      chk("rd_addr", longint'(rd_addr), (m_active && m_n < N) ? longint'(m_n) : 0);
      chk("i_syn", longint'(i_syn), m_isyn);
    end
  end

  task automatic run_acc(input logic [N-1:0] v, input bit mid,
                         output int lat, output int busy_n, output int dones);
    @(negedge clk);
    start  = 1'b1;
    spikes = v;
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    dones  = 0;
    for (int j = 1; j <= N + 5; j++) begin
      if (j > 1) @(negedge clk);
      if (mid && j == 10) begin
        start  = 1'b1;
        spikes = '0;
      end else if (mid && j == 11) begin
        start = 1'b0;
      end
      #1;
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (lat == 0) lat = j;
      end
    end
  endtask

  task automatic fill_const(input logic [31:0] w);
    for (int i = 0; i < N; i++) ram[i] = w;
  endtask

  task automatic fill_rand(input int span);
    for (int i = 0; i < N; i++)
      ram[i] = 32'($signed($urandom_range(2 * span, 0)) - span);
  endtask

  int lat, bn, dn;
  logic [N-1:0] v;
  longint e;

  initial begin
    fill_const(32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_i_syn", longint'(i_syn), 0);
    chk("reset_busy", longint'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All weights 1, all spikes
    fill_const(32'd1);
    run_acc({N{1'b1}}, 0, lat, bn, dn);
    chk("ones_latency", lat, 65);
    chk("ones_i_syn", longint'(i_syn), 64);

    // Two selected weights
    fill_const(32'd0);
    ram[3]  = 32'd100;
    ram[10] = -32'sd30;
    v = '0;
    v[3] = 1'b1;
    v[10] = 1'b1;
    run_acc(v, 0, lat, bn, dn);
    chk("pair_i_syn", longint'(i_syn), 70);

    // Positive and negative clamp
    fill_const(32'h0000_7FFF);
    run_acc({N{1'b1}}, 0, lat, bn, dn);
    chk("sat_hi", longint'(i_syn), 32767);
    fill_const(32'hFFFF_8000);
    run_acc({N{1'b1}}, 0, lat, bn, dn);
    chk("sat_lo", longint'(i_syn), -32768);

    // Restart and spike change during scan are ignored
    fill_rand(1000);
    v = {$urandom, $urandom};
    e = exp_sum(v);
    run_acc(v, 1, lat, bn, dn);
    chk("mid_dones", dn, 1);
    chk("mid_busy_cycles", bn, N + 1);
    chk("mid_i_syn", longint'(i_syn), e);

    // Reset at k=20 aborts the scan
    @(negedge clk);
    start  = 1'b1;
    spikes = {N{1'b1}};
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("pre_rst_addr", longint'(rd_addr), 20);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_rd_addr", longint'(rd_addr), 0);
    chk("abort_i_syn", longint'(i_syn), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_rand(500);
    v = {$urandom, $urandom};
    e = exp_sum(v);
    run_acc(v, 0, lat, bn, dn);
    chk("after_rst_i_syn", longint'(i_syn), e);
    chk("after_rst_latency", lat, 65);

    // Zero-spike vector
    run_acc('0, 0, lat, bn, dn);
    chk("zero_latency", lat, 65);
    chk("zero_i_syn", longint'(i_syn), 0);

    // Random weights and spikes, including full-range words
    for (int t = 0; t < 8; t++) begin
      if (t < 4) fill_rand(1500);
      else for (int i = 0; i < N; i++) ram[i] = $urandom;
      v = {$urandom, $urandom};
      e = exp_sum(v);
      run_acc(v, 0, lat, bn, dn);
      chk("rand_i_syn", longint'(i_syn), e);
      chk("rand_dones", dn, 1);
    end

    @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
